crc_code_ctrl_arbiter: RTL

Parametrised control unit for the bit-serial CRC datapath. It serves NUM_CH independent requesters, for example the memory write (encode) and read (check) paths, on one shared CRC shift engine. It arbitrates round-robin, sequences load and shift for a configurable message and CRC width, and reports completion and a per-channel check result. It replaces the fixed two-instance encoder/decoder controller pair.

---
 rtl/crc_code_pkg.sv | 30 +++
 rtl/crc_code_rr_arbiter.sv | 28 ++
 rtl/crc_code_ctrl_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/crc_code_pkg.sv
// Shared types and width helpers for the CRC engine control unit and its arbiter.
package crc_code_pkg;

    localparam int unsigned DEFAULT_NUM_CH     = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_CRC_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Total bits shifted per transaction: message followed by CRC.
    function automatic int unsigned shift_len(input int unsigned data_w, input int unsigned crc_w);
        return data_w + crc_w;
    endfunction

    // Width of the shift index counter.
    function automatic int unsigned cnt_w(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    // Width of a channel index.
    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/crc_code_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module crc_code_rr_arbiter
    import crc_code_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [ch_w(NUM_CH)-1:0]   last_grant,
    input  logic                      enable,
    output logic [ch_w(NUM_CH)-1:0]   grant,
    output logic                      grant_valid
);

    localparam int unsigned CH_W = ch_w(NUM_CH);

    // Scan channels last_grant+1 .. last_grant+NUM_CH; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            if (enable && !grant_valid && req[CH_W'((32'(last_grant) + k) % NUM_CH)]) begin
                grant       = CH_W'((32'(last_grant) + k) % NUM_CH);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crc_code_ctrl_arbiter.sv
// Shared bit-serial CRC engine controller: round-robin request arbitration,
// load/shift sequencing and per-channel check result.
// Optional feature macro: CRC_CODE_CTRL_ABORT_EN adds an abort input that
// cancels the transaction in LOAD or SHIFT.
module crc_code_ctrl_arbiter
    import crc_code_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEFAULT_NUM_CH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CRC_WIDTH  = DEFAULT_CRC_WIDTH
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_CH-1:0]                                   start,
    input  logic [NUM_CH-1:0]                                   check_mode,
    input  logic                                                syndrome_zero,
`ifdef CRC_CODE_CTRL_ABORT_EN
    input  logic                                                abort,
`endif
    output logic                                                load_en,
    output logic                                                shift_en,
    output logic [ch_w(NUM_CH)-1:0]                             ch_sel,
    output logic [cnt_w(shift_len(DATA_WIDTH, CRC_WIDTH))-1:0]  bit_idx,
    output logic [NUM_CH-1:0]                                   data_valid,
    output logic [NUM_CH-1:0]                                   crc_err,
    output logic [NUM_CH-1:0]                                   busy,
    output logic                                                engine_busy
);

    localparam int unsigned SHIFT_LEN = shift_len(DATA_WIDTH, CRC_WIDTH);
    localparam int unsigned CNT_W     = cnt_w(SHIFT_LEN);
    localparam int unsigned CH_W      = ch_w(NUM_CH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SHIFT_LEN - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d, ch_sel_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [NUM_CH-1:0]   pending_q, pending_d, mode_q, mode_d, crc_err_d;
    logic [NUM_CH-1:0]   accept, sel_oh, next_oh;
    logic [NUM_CH-1:0]   data_valid_d, busy_d;
    logic                load_en_d, shift_en_d, engine_busy_d;
    logic                arb_en, arb_valid, abort_req, done_err;
    logic [CH_W-1:0]     arb_grant;

`ifdef CRC_CODE_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Requests are only taken from idle channels; the rest are dropped.
    assign accept   = start & ~busy;
    assign sel_oh   = NUM_CH'(1) << ch_sel;
    assign done_err = (|(mode_q & sel_oh)) & ~syndrome_zero;
    assign arb_en   = (state_q == ST_IDLE) || (state_q == ST_DONE);

    crc_code_rr_arbiter #(
        .NUM_CH      (NUM_CH)
    ) u_rr_arbiter (
        .req         (pending_q),
        .last_grant  (last_grant_q),
        .enable      (arb_en),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Next-state, bookkeeping and next-output decode.
    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel;
        last_grant_d = last_grant_q;
        cnt_d        = bit_idx;
        pending_d    = pending_q | accept;
        mode_d       = (mode_q & ~accept) | (check_mode & accept);
        crc_err_d    = crc_err;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d      = ST_LOAD;
                    ch_sel_d     = arb_grant;
                    last_grant_d = arb_grant;
                end
            end
            ST_LOAD: begin
                pending_d = pending_d & ~sel_oh;
                crc_err_d = crc_err & ~sel_oh;
                cnt_d     = '0;
                state_d   = abort_req ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bit_idx == LAST_IDX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = bit_idx + CNT_W'(1);
                end
            end
            ST_DONE: begin
                crc_err_d = (crc_err & ~sel_oh) | (done_err ? sel_oh : '0);
                if (arb_valid) begin
                    state_d      = ST_LOAD;
                    ch_sel_d     = arb_grant;
                    last_grant_d = arb_grant;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        next_oh       = NUM_CH'(1) << ch_sel_d;
        load_en_d     = (state_d == ST_LOAD);
        shift_en_d    = (state_d == ST_SHIFT);
        engine_busy_d = (state_d != ST_IDLE);
        data_valid_d  = (state_d == ST_DONE) ? next_oh : '0;
        busy_d        = pending_d | (engine_busy_d ? next_oh : '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CH_W'(NUM_CH - 1);
            ch_sel       <= '0;
            bit_idx      <= '0;
            pending_q    <= '0;
            mode_q       <= '0;
            crc_err      <= '0;
            load_en      <= 1'b0;
            shift_en     <= 1'b0;
            engine_busy  <= 1'b0;
            data_valid   <= '0;
            busy         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ch_sel       <= ch_sel_d;
            bit_idx      <= cnt_d;
            pending_q    <= pending_d;
            mode_q       <= mode_d;
            crc_err      <= crc_err_d;
            load_en      <= load_en_d;
            shift_en     <= shift_en_d;
            engine_busy  <= engine_busy_d;
            data_valid   <= data_valid_d;
            busy         <= busy_d;
        end
    end

endmodule
